link_credit_arbiter: RTL and testbench

Credit-gated round-robin arbiter that shares the single byte-wide upstream port of the off-chip link serializer between two requesters. It tracks free entries in the link's 4-bit downstream buffer and grants a byte only when enough entries are free. It returns credit as the link read side drains the buffer. It sits directly in front of the link serializer's `data_in`/`valid_in` inputs.

---
 rtl/link_credit_arbiter_pkg.sv | 14 +
 rtl/link_credit_arbiter_rr_pick2.sv | 19 +
 rtl/link_credit_arbiter.sv | 102 ++++++++++
 tb/tb_link_credit_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_credit_arbiter_pkg.sv
// rtl/link_credit_arbiter_pkg.sv - shared link constants and arbiter state encoding
package link_credit_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } link_state_t;

    // Kept in one place so the serializer's buffer depth and token size match.
    localparam int CREDITS_DEFAULT = 8;
    localparam int COST_DEFAULT    = 2;
    localparam int RET_DEFAULT     = 4;

endpackage

// File: rtl/link_credit_arbiter_rr_pick2.sv
// rtl/link_credit_arbiter_rr_pick2.sv - combinational 2-way round-robin selector
module link_credit_arbiter_rr_pick2 (
    input  logic [1:0] req_valid,
    input  logic       last_id,
    output logic       winner,
    output logic       any_valid
);

    always_comb begin
        any_valid = |req_valid;
        // On a tie the requester that did not win last time goes next.
        if (&req_valid) begin
            winner = ~last_id;
        end else begin
            winner = req_valid[1];
        end
    end

endmodule

// File: rtl/link_credit_arbiter.sv
// rtl/link_credit_arbiter.sv - credit-gated round-robin arbiter in front of the link serializer
module link_credit_arbiter
    import link_credit_arbiter_pkg::*;
#(
    parameter int CREDITS = CREDITS_DEFAULT,
    parameter int COST    = COST_DEFAULT,
    parameter int RET     = RET_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [1:0]                       req_valid,
    input  logic [7:0]                       req_data0,
    input  logic [7:0]                       req_data1,
    output logic [1:0]                       req_ready,
    output logic                             out_valid,
    output logic [7:0]                       out_data,
    output logic                             out_id,
    input  logic                             out_ready,
    input  logic                             credit_ret,
    output logic [$clog2(CREDITS+1)-1:0]     credit_cnt,
    output logic                             credit_err
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int NW = CW + 1;

    link_state_t state;
    logic        last_id;
    logic        winner;
    logic        any_valid;
    logic        xfer;
    logic [NW-1:0] credit_sum;

    link_credit_arbiter_rr_pick2 u_pick (
        .req_valid (req_valid),
        .last_id   (last_id),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Only registered state and req_valid feed req_ready.
    always_comb begin
        req_ready = 2'b00;
        if (state == ST_IDLE && any_valid && credit_cnt >= CW'(COST)) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign xfer = out_valid & out_ready;

    always_comb begin
        credit_sum = {1'b0, credit_cnt};
        if (xfer) begin
            credit_sum = credit_sum - NW'(COST);
        end
        if (credit_ret) begin
            credit_sum = credit_sum + NW'(RET);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_cnt <= CW'(CREDITS);
            credit_err <= 1'b0;
        end else if (credit_sum > NW'(CREDITS)) begin
            credit_cnt <= CW'(CREDITS);
            credit_err <= 1'b1;
        end else begin
            credit_cnt <= credit_sum[CW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_id    <= 1'b0;
            last_id   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req_ready) begin
                        out_data  <= winner ? req_data1 : req_data0;
                        out_id    <= winner;
                        out_valid <= 1'b1;
                        last_id   <= winner;
                        state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_link_credit_arbiter.sv
// tb/tb_link_credit_arbiter.sv - self-checking bench for link_credit_arbiter
module tb_link_credit_arbiter;

    localparam int CREDITS = 8;
    localparam int COST    = 2;
    localparam int RET     = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [7:0] req_data0;
    logic [7:0] req_data1;
    logic [1:0] req_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_id;
    logic       out_ready;
    logic       credit_ret;
    logic [3:0] credit_cnt;
    logic       credit_err;

    int checks   = 0;
    int failures = 0;

    link_credit_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data0  (req_data0),
        .req_data1  (req_data1),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_ready  (out_ready),
        .credit_ret (credit_ret),
        .credit_cnt (credit_cnt),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    // Reference model: a byte slot, an integer credit pool and the last grantee.
    logic       m_busy;
    logic [7:0] m_data;
    logic       m_id;
    logic       m_last;
    logic       m_err;
    int         m_cnt;

    function automatic logic [1:0] exp_ready(input logic [1:0] v);
        logic w;
        if (m_busy || m_cnt < COST || v == 2'b00) return 2'b00;
        w = (v == 2'b11) ? ~m_last : v[1];
        return w ? 2'b10 : 2'b01;
    endfunction

    always @(posedge clk) begin
        int         n;
        logic [1:0] g;
        if (rst) begin
            m_busy <= 1'b0;
            m_data <= 8'h00;
            m_id   <= 1'b0;
            m_last <= 1'b1;
            m_err  <= 1'b0;
            m_cnt  <= CREDITS;
        end else begin
            n = m_cnt;
            if (m_busy && out_ready) n = n - COST;
            if (credit_ret) n = n + RET;
            if (n > CREDITS) begin
                n = CREDITS;
                m_err <= 1'b1;
            end
            m_cnt <= n;
            g = exp_ready(req_valid);
            if (m_busy && out_ready) m_busy <= 1'b0;
            if (g != 2'b00) begin
                m_busy <= 1'b1;
                m_data <= g[1] ? req_data1 : req_data0;
                m_id   <= g[1];
                m_last <= g[1];
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        req_valid  = 2'b00;
        req_data0  = 8'h00;
        req_data1  = 8'h00;
        out_ready  = 1'b0;
        credit_ret = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got %02h exp 00", out_data); end
        checks++; if (out_id !== 1'b0) begin failures++; $display("FAIL reset_out_id got %0b exp 0", out_id); end
        checks++; if (credit_cnt !== 4'd8) begin failures++; $display("FAIL reset_credit_cnt got %0d exp 8", credit_cnt); end
        checks++; if (credit_err !== 1'b0) begin failures++; $display("FAIL reset_credit_err got %0b exp 0", credit_err); end
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got %02b exp 00", req_ready); end
    endtask

    task automatic test_single_byte();
        do_reset();
        req_valid = 2'b01;
        req_data0 = 8'h05;
        out_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_ready got %02b exp 01", req_ready); end
        cyc();
        req_valid = 2'b00;
        #1;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid got %0b exp 1", out_valid); end
        checks++; if (out_data !== 8'h05) begin failures++; $display("FAIL single_out_data got %02h exp 05", out_data); end
        checks++; if (out_id !== 1'b0) begin failures++; $display("FAIL single_out_id got %0b exp 0", out_id); end
        checks++; if (credit_cnt !== 4'd8) begin failures++; $display("FAIL single_cnt_before got %0d exp 8", credit_cnt); end
        cyc();
        #1;
        checks++; if (credit_cnt !== 4'd6) begin failures++; $display("FAIL single_cnt_after got %0d exp 6", credit_cnt); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_out_valid_clear got %0b exp 0", out_valid); end
    endtask

    task automatic test_tie_alternation();
        int k = 0;
        do_reset();
        req_valid = 2'b11;
        req_data0 = 8'hA0;
        req_data1 = 8'hB1;
        out_ready = 1'b1;
        for (int c = 0; c < 60 && k < 8; c++) begin
            credit_ret = (c % 4 == 3);
            #1;
            if (out_valid) begin
                checks++;
                if (out_id !== k[0]) begin failures++; $display("FAIL tie_id byte %0d got %0b exp %0b", k, out_id, k[0]); end
                checks++;
                if (out_data !== (k[0] ? 8'hB1 : 8'hA0)) begin
                    failures++; $display("FAIL tie_data byte %0d got %02h exp %02h", k, out_data, k[0] ? 8'hB1 : 8'hA0);
                end
                k++;
            end
            cyc();
        end
        credit_ret = 1'b0;
        checks++; if (k < 8) begin failures++; $display("FAIL tie_timeout got %0d bytes exp 8", k); end
    endtask

    task automatic test_exhaustion();
        int n = 0;
        do_reset();
        req_valid = 2'b11;
        req_data0 = 8'h11;
        req_data1 = 8'h22;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (out_valid) n++;
            cyc();
        end
        #1;
        checks++; if (n != 4) begin failures++; $display("FAIL exhaust_count got %0d exp 4", n); end
        checks++; if (credit_cnt !== 4'd0) begin failures++; $display("FAIL exhaust_cnt got %0d exp 0", credit_cnt); end
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL exhaust_ready got %02b exp 00", req_ready); end
        credit_ret = 1'b1;
        cyc();
        credit_ret = 1'b0;
        #1;
        checks++; if (credit_cnt !== 4'd4) begin failures++; $display("FAIL exhaust_ret_cnt got %0d exp 4", credit_cnt); end
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL exhaust_ret_ready got %02b exp 01", req_ready); end
        cyc();
        #1;
        checks++; if (out_valid !== 1'b1 || out_id !== 1'b0) begin
            failures++; $display("FAIL exhaust_accept got valid=%0b id=%0b exp valid=1 id=0", out_valid, out_id);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 2'b01;
        req_data0 = 8'h3C;
        out_ready = 1'b0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            req_data0 = 8'($urandom);
            #1;
            checks++; if (out_data !== 8'h3C) begin failures++; $display("FAIL bp_data cycle %0d got %02h exp 3c", i, out_data); end
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid cycle %0d got %0b exp 1", i, out_valid); end
            checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_ready cycle %0d got %02b exp 00", i, req_ready); end
            checks++; if (credit_cnt !== 4'd8) begin failures++; $display("FAIL bp_cnt cycle %0d got %0d exp 8", i, credit_cnt); end
            cyc();
        end
        req_valid = 2'b00;
        out_ready = 1'b1;
        cyc();
        #1;
        checks++; if (out_valid !== 1'b0 || credit_cnt !== 4'd6) begin
            failures++; $display("FAIL bp_release got valid=%0b cnt=%0d exp valid=0 cnt=6", out_valid, credit_cnt);
        end
        cyc();
        #1;
        checks++; if (out_valid !== 1'b0 || credit_cnt !== 4'd6) begin
            failures++; $display("FAIL bp_single got valid=%0b cnt=%0d exp valid=0 cnt=6", out_valid, credit_cnt);
        end
    endtask

    task automatic test_simultaneous();
        logic hit = 1'b0;
        do_reset();
        req_valid = 2'b01;
        req_data0 = 8'h5A;
        out_ready = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            #1;
            if (out_valid && credit_cnt == 4'd2) begin
                out_ready  = 1'b1;
                credit_ret = 1'b1;
                req_valid  = 2'b00;
                hit        = 1'b1;
            end else begin
                out_ready = out_valid;
            end
            cyc();
        end
        credit_ret = 1'b0;
        out_ready  = 1'b0;
        #1;
        checks++; if (!hit) begin failures++; $display("FAIL simul_timeout got no hold at cnt 2 exp hold at cnt 2"); end
        checks++; if (credit_cnt !== 4'd4) begin failures++; $display("FAIL simul_cnt got %0d exp 4", credit_cnt); end
        checks++; if (credit_err !== 1'b0) begin failures++; $display("FAIL simul_err got %0b exp 0", credit_err); end

        do_reset();
        credit_ret = 1'b1;
        cyc();
        credit_ret = 1'b0;
        #1;
        checks++; if (credit_cnt !== 4'd8) begin failures++; $display("FAIL sat_cnt got %0d exp 8", credit_cnt); end
        checks++; if (credit_err !== 1'b1) begin failures++; $display("FAIL sat_err got %0b exp 1", credit_err); end
        cyc();
        cyc();
        #1;
        checks++; if (credit_err !== 1'b1) begin failures++; $display("FAIL sat_sticky got %0b exp 1", credit_err); end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        req_valid = 2'b01;
        req_data0 = 8'h77;
        out_ready = 1'b0;
        cyc();
        #1;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre got %0b exp 1", out_valid); end
        rst       = 1'b1;
        req_valid = 2'b00;
        cyc();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got %0b exp 0", out_valid); end
        checks++; if (credit_cnt !== 4'd8) begin failures++; $display("FAIL midrst_cnt got %0d exp 8", credit_cnt); end
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL midrst_tie got %02b exp 01", req_ready); end
        cyc();
        #1;
        checks++; if (out_valid !== 1'b1 || out_id !== 1'b0) begin
            failures++; $display("FAIL midrst_grant got valid=%0b id=%0b exp valid=1 id=0", out_valid, out_id);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req_valid  = 2'($urandom_range(0, 3));
            req_data0  = 8'($urandom);
            req_data1  = 8'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            credit_ret = ($urandom_range(0, 5) == 0);
            #1;
            checks++; if (req_ready !== exp_ready(req_valid)) begin
                failures++; $display("FAIL rand_ready cycle %0d got %02b exp %02b", c, req_ready, exp_ready(req_valid));
            end
            checks++; if (out_valid !== m_busy) begin failures++; $display("FAIL rand_valid cycle %0d got %0b exp %0b", c, out_valid, m_busy); end
            checks++; if (out_data !== m_data) begin failures++; $display("FAIL rand_data cycle %0d got %02h exp %02h", c, out_data, m_data); end
            checks++; if (out_id !== m_id) begin failures++; $display("FAIL rand_id cycle %0d got %0b exp %0b", c, out_id, m_id); end
            checks++; if (credit_cnt !== 4'(m_cnt)) begin failures++; $display("FAIL rand_cnt cycle %0d got %0d exp %0d", c, credit_cnt, m_cnt); end
            checks++; if (credit_err !== m_err) begin failures++; $display("FAIL rand_err cycle %0d got %0b exp %0b", c, credit_err, m_err); end
            cyc();
        end
        credit_ret = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 2'b00;
        req_data0  = 8'h00;
        req_data1  = 8'h00;
        out_ready  = 1'b0;
        credit_ret = 1'b0;
        test_reset();
        test_single_byte();
        test_tie_alternation();
        test_exhaustion();
        test_backpressure();
        test_simultaneous();
        test_reset_mid_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
